// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and write-back payload bundle for the MEM->WB stage
package pipe_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] mem_data;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_REG_W-1:0]  rd;
        logic                  mem_to_reg;
        logic                  reg_write;
    } wb_payload_t;

    localparam int WB_PAYLOAD_W = $bits(wb_payload_t);
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: valid/ready register with flush; PIPE_WB_SKID_EN adds a second (skid) entry
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = WB_PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_v_q, main_v_d;
    logic [W-1:0] main_q, main_d;
    logic         in_xfer, out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_v_q & out_ready;
    assign out_valid = main_v_q;
    assign out_data  = main_q;

`ifdef PIPE_WB_SKID_EN
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] skid_q, skid_d;
    logic         load_main, to_skid;

    assign in_ready  = rst_n & ~skid_v_q;
    assign load_main = in_xfer & (~main_v_q | out_xfer);
    assign to_skid   = in_xfer & main_v_q & ~out_ready;

    // main refills from skid first to keep order; a stalled full main diverts input into skid
    always_comb begin
        main_v_d = ~flush & (load_main | (skid_v_q & out_xfer) | (main_v_q & ~out_xfer));
        main_d   = (skid_v_q & out_xfer) ? skid_q : load_main ? in_data : main_q;
        skid_v_d = ~flush & (to_skid | (skid_v_q & ~out_xfer));
        skid_d   = to_skid ? in_data : skid_q;
    end

    // skid storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_v_q <= 1'b0;
            skid_q   <= '0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
        end
    end
`else
    assign in_ready = rst_n & (~main_v_q | out_ready);

    // single entry: accepted input always lands in main, which is empty or draining
    always_comb begin
        main_v_d = ~flush & (in_xfer | (main_v_q & ~out_xfer));
        main_d   = in_xfer ? in_data : main_q;
    end
`endif

    // main storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
        end
    end
endmodule

// File: rtl/pipe_wb_stage.sv
// pipe_wb_stage: MEM->WB stage with flush, reg_write gating and write-back mux (skid buffer under PIPE_WB_SKID_EN)
module pipe_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              out_mem_to_reg
);
    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_W-1:0]  rd;
        logic              mem_to_reg;
        logic              reg_write;
    } payload_t;

    payload_t in_p, out_p;

    assign in_p = '{mem_data: in_mem_data, alu_result: in_alu_result, rd: in_rd,
                    mem_to_reg: in_mem_to_reg, reg_write: in_reg_write};

    pipe_skid_buf #(.W($bits(payload_t))) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_p)
    );

    assign out_rd         = out_p.rd;
    assign out_mem_to_reg = out_p.mem_to_reg;
    assign out_reg_write  = out_p.reg_write & out_valid;
    assign out_wb_data    = out_p.mem_to_reg ? out_p.mem_data : out_p.alu_result;
endmodule
